// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
// Shared project definitions for the Common Data Bus arbiter slice.
//   NUM_FU   - number of functional units competing for the CDB
//   XLEN     - width of a result value
//   ROB_LEN  - reorder buffer depth (power of two), TAG_W bits per tag
//   SRC_W    - width of an FU index carried on the CDB
// Packets:
//   fu_result_packet_t - one FU's completed result (valid, tag, value)
//   cdb_packet_t       - one CDB broadcast (valid, tag, value, src)
package cdb_arbiter_pkg;

    localparam int NUM_FU  = 4;
    localparam int XLEN    = 32;
    localparam int ROB_LEN = 8;
    localparam int TAG_W   = $clog2(ROB_LEN);
    localparam int SRC_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    localparam logic [31:0] BUSY_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } fu_result_packet_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        logic [SRC_W-1:0] src;
    } cdb_packet_t;

    // Round-robin successor of an FU index; NUM_FU need not be a power of two,
    // so the wrap is explicit rather than relying on overflow.
    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] idx);
        logic [SRC_W-1:0] nxt;
        if (int'(idx) == NUM_FU - 1) begin
            nxt = '0;
        end else begin
            nxt = idx + SRC_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
// Bundles the FU request side and the CDB broadcast side of the arbiter.
//   fu_valid / fu_tag / fu_value - per-FU completed results (FU -> arbiter)
//   fu_ready                     - one-hot grant (arbiter -> FU)
//   cdb_valid / cdb_tag / cdb_value / cdb_src - registered broadcast
//   busy_cycles                  - saturating CDB utilisation counter
// Modports:
//   master - the arbiter itself (owns grants and the bus)
//   slave  - FUs, ROB and reservation stations
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic [NUM_FU-1:0]            fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
    logic [NUM_FU-1:0]            fu_ready;

    logic                         cdb_valid;
    logic [TAG_W-1:0]             cdb_tag;
    logic [XLEN-1:0]              cdb_value;
    logic [SRC_W-1:0]             cdb_src;
    logic [31:0]                  busy_cycles;

    modport master (
        input  fu_valid, fu_tag, fu_value,
        output fu_ready,
        output cdb_valid, cdb_tag, cdb_value, cdb_src, busy_cycles
    );

    modport slave (
        output fu_valid, fu_tag, fu_value,
        input  fu_ready,
        input  cdb_valid, cdb_tag, cdb_value, cdb_src, busy_cycles
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker
// Purely combinational round-robin selector.
//   req     - request vector, one bit per FU
//   ptr     - index with highest priority this cycle
//   gnt     - one-hot grant (zero when nothing requests)
//   gnt_idx - index of the granted FU (zero when nothing requests)
//   any_gnt - a grant was issued
module rr_picker #(
    parameter int NUM_FU = 4,
    parameter int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_FU-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    // Walk the FUs starting at ptr and wrapping once; the first requester
    // wins and later ones are masked off by any_gnt.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Shares the single Common Data Bus among NUM_FU functional units. Each cycle
// at most one completed FU result is granted (round-robin) and broadcast on
// the registered CDB one cycle later.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high reset
//   squash - pipeline flush; blocks this cycle's grant
//   bus    - cdb_arbiter_if master modport (FU requests, grants, CDB, counter)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    cdb_arbiter_if.master bus
);

    logic [SRC_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] gnt;
    logic [SRC_W-1:0]  gnt_idx;
    logic              any_gnt;
    cdb_packet_t       cdb_q;
    logic [31:0]       busy_cycles_q;
    fu_result_packet_t fu_res [NUM_FU];

    // Gather the per-FU results into packets and qualify the requests: reset
    // and squash both suppress every grant so no result is consumed.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_res[i].valid = bus.fu_valid[i];
            fu_res[i].tag   = bus.fu_tag[i];
            fu_res[i].value = bus.fu_value[i];
            req[i]          = fu_res[i].valid && !reset && !squash;
        end
    end

    rr_picker #(
        .NUM_FU (NUM_FU),
        .IDX_W  (SRC_W)
    ) u_picker (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // Broadcast register, round-robin pointer and utilisation counter. The
    // counter looks at the broadcast currently on the bus, so it trails the
    // visible cdb_valid by one cycle and saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr        <= '0;
            cdb_q         <= '0;
            busy_cycles_q <= '0;
        end else begin
            cdb_q.valid <= any_gnt;
            if (any_gnt) begin
                cdb_q.tag   <= fu_res[gnt_idx].tag;
                cdb_q.value <= fu_res[gnt_idx].value;
                cdb_q.src   <= gnt_idx;
                rr_ptr      <= next_ptr(gnt_idx);
            end
            if (cdb_q.valid && (busy_cycles_q != BUSY_MAX)) begin
                busy_cycles_q <= busy_cycles_q + 32'd1;
            end
        end
    end

    assign bus.fu_ready    = gnt;
    assign bus.cdb_valid   = cdb_q.valid;
    assign bus.cdb_tag     = cdb_q.tag;
    assign bus.cdb_value   = cdb_q.value;
    assign bus.cdb_src     = cdb_q.src;
    assign bus.busy_cycles = busy_cycles_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Round-robin scheduler that shares the single Common Data Bus among NUM_FU functional units.
Each cycle it selects at most one completing FU result (ROB tag + value) and broadcasts it on a registered CDB output.
The ROB (which sets an entry's value-valid bit) and the reservation stations (for tag wakeup) consume this output.
It also keeps a saturating CDB-utilisation counter for performance reporting.

Parameters:
NUM_FU, 4, number of requesting functional units (>=2)
XLEN, 32, result value width
ROB_LEN, 8, ROB depth (power of two); tag width TAG_W = $clog2(ROB_LEN)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  pipeline flush (branch mispredict); kills in-flight broadcast
fu_valid  in  NUM_FU  FU i holds a completed result
fu_tag  in  NUM_FU x TAG_W  ROB tag of FU i's result
fu_value  in  NUM_FU x XLEN  result value of FU i
fu_ready  out  NUM_FU  one-hot grant; FU i's result accepted this cycle
cdb_valid  out  1  CDB broadcast valid
cdb_tag  out  TAG_W  broadcast ROB tag
cdb_value  out  XLEN  broadcast value
cdb_src  out  $clog2(NUM_FU)  index of FU that produced the broadcast
busy_cycles  out  32  count of cycles with cdb_valid=1, saturates at 32'hFFFF_FFFF

Behaviour:
- Reset: cdb_valid=0; cdb_tag, cdb_value, cdb_src, busy_cycles = 0; round-robin pointer rr_ptr=0; fu_ready=0 during every reset cycle.
- Handshake:
  - Transfer occurs when fu_valid[i] && fu_ready[i].
  - FU holds valid, tag and value stable until it is granted. Valid must not drop before grant; if it does, the request is simply not granted.
- Grant (combinational):
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first with fu_valid=1 receives fu_ready=1.
  - At most one bit of fu_ready is set.
  - fu_ready=0 for all FUs when squash=1 or reset=1.
- Pointer update:
  - On transfer from FU g: rr_ptr <= (g+1) mod NUM_FU.
  - No transfer: rr_ptr holds.
  - squash does not move rr_ptr.
- Latency: exactly one cycle. A result granted in cycle N appears on cdb_* in cycle N+1 with cdb_valid=1 for exactly that one cycle.
- In any cycle with no transfer, cdb_valid <= 0. cdb_tag, cdb_value and cdb_src hold their last values (don't-care).
- Back-to-back: a grant every cycle is allowed, giving full CDB throughput.
- Fairness: a continuously valid FU is granted within NUM_FU cycles of asserting valid.
- Squash in cycle N:
  - No grant in N.
  - cdb_valid=0 in N+1.
  - Any broadcast already showing in cycle N is unaffected (it is already visible).
  - Requesters are responsible for dropping their own squashed results.
- busy_cycles increments on each cycle where cdb_valid=1. It stops at all-ones.
- Reset asserted mid-operation overrides squash and all requests; all state returns to reset values on the next edge.
- Tag value 0 is a legal ROB tag; only cdb_valid qualifies a broadcast.

Decomposition:
- Shared package (project defines file): XLEN, ROB_LEN, NUM_FU; typedef CDB_PACKET {valid, tag, value, src}; typedef FU_RESULT_PACKET {valid, tag, value}.
- Top-level ports use these packets where the codebase already does.
- One sub-module: rr_picker.
  - Parameterised NUM_FU.
  - Inputs req[NUM_FU] and ptr; outputs one-hot gnt, gnt_idx and any_gnt.
  - Purely combinational; rr_ptr state lives in cdb_arbiter.

Test Plan:
1. Reset held 2 cycles with all fu_valid=1 -> fu_ready=0, cdb_valid=0, busy_cycles=0; first cycle after reset grants FU0 (rr_ptr=0).
2. Only FU2 valid, tag=5, value=32'hDEAD_BEEF, in cycle N -> fu_ready=4'b0100 in N; cycle N+1 cdb_valid=1, tag=5, value=DEADBEEF, src=2; cycle N+2 cdb_valid=0.
3. All four FUs valid continuously, tags 1..4 -> grants FU0,FU1,FU2,FU3,FU0 on consecutive cycles; cdb_valid=1 every cycle from the second; busy_cycles=4 after four broadcasts.
4. After a grant to FU3 (rr_ptr=0), FU1 and FU3 valid -> FU1 granted first, then FU3 next cycle.
5. FU0 valid with squash=1 in cycle N -> fu_ready=0 in N, cdb_valid=0 in N+1; squash deasserted in N+1 -> FU0 granted in N+1, broadcast in N+2.
6. busy_cycles preloaded (force) to 32'hFFFF_FFFE with two back-to-back broadcasts -> reaches 32'hFFFF_FFFF and stays there; reset mid-stream -> cdb_valid=0 and busy_cycles=0 next cycle.
